sensor_scan_scheduler: RTL
==========================

// Module: sensor_scan_scheduler
// PURPOSE
//  Sequences the four environmental sensor channels (0=soil, 1=temp, 2=humid, 3=light) through a shared 8-bit ADC.
//  Per channel it drives the analog mux select, waits a settle time, performs an ADC req/ack handshake, and
//  emits one sample_valid pulse toward the averaging/threshold datapath. It also arbitrates the shared pixel
//  bus between sensor scans and camera frames, granting camera mode only at channel boundaries.
// PARAMETERS
//  SETTLE_CYCLES  16    cycles mux_sel is held stable before adc_req asserts (>=1)
//  ACK_TIMEOUT    255   max cycles adc_req may stay high without adc_ack (>=1)
//  SCAN_PERIOD    1024  cycles between scan-start ticks (>=2)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-high
//  run           in   1  enables periodic scanning (level)
//  ch_mask       in   4  bit n=1 -> channel n included in each scan
//  adc_req       out  1  ADC conversion request
//  adc_ack       in   1  ADC handshake; data valid in the same cycle
//  adc_data      in   8  ADC conversion result
//  mux_sel       out  2  analog mux / sensor_sel drive
//  sample_valid  out  1  one-cycle pulse: sample_ch/sample_data valid
//  sample_ch     out  2  channel of the presented sample
//  sample_data   out  8  captured ADC value
//  cam_req       in   1  host requests the pixel bus for camera mode (level)
//  cam_grant     out  1  camera owns the bus; drives mode_camera
//  busy          out  1  1 in any state other than IDLE
//  err_clr       in   1  clears timeout_err and overrun
//  timeout_err   out  1  sticky: an ADC ack timeout occurred
//  overrun       out  1  sticky: a period tick arrived while a scan or camera grant was active
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period counter 0, pending-start flag 0.
//  Period timer: counts 0..SCAN_PERIOD-1 while run=1 and wraps; tick = (count==SCAN_PERIOD-1).
//   The counter holds at 0 while run=0.
//  FSM states: IDLE, SETTLE, REQ, CAP, NEXT, CAM.
//  IDLE:
//   - cam_req=1 -> CAM (priority over scans).
//   - Otherwise (tick or pending) and ch_mask!=0 -> SETTLE on the lowest enabled channel; clear pending.
//   - ch_mask=0: ticks are ignored and pending is cleared.
//  SETTLE: mux_sel=ch. Stays exactly SETTLE_CYCLES cycles, then -> REQ.
//  REQ: adc_req=1.
//   - adc_req&&adc_ack -> latch adc_data, -> CAP.
//   - Else after ACK_TIMEOUT cycles in REQ -> set timeout_err, drop adc_req, -> NEXT, no sample_valid.
//   - Ack on the timeout cycle counts as success; timeout_err is not set.
//  CAP: sample_valid=1 for one cycle with sample_ch=ch and the latched data. Latency: ack edge -> valid next cycle.
//   adc_req is low in CAP. -> NEXT.
//  NEXT: selects the next enabled channel above ch, ascending, with no wrap inside a scan; ch_mask is re-sampled here.
//   - cam_req=1 -> CAM; the remaining channels resume afterwards.
//   - Else if a higher enabled channel exists and run=1 -> SETTLE on it.
//   - Else -> IDLE. run=0 mid-scan finishes the current channel, then IDLE.
//  CAM: cam_grant=1; adc_req=0; mux_sel holds.
//   - cam_req=0 -> cam_grant drops next cycle.
//   - Then resume the interrupted scan (SETTLE on the saved next channel) or IDLE.
//  Tick while state!=IDLE: set overrun and set pending; the scan starts on the first IDLE cycle after.
//   Multiple ticks collapse into one pending.
//  err_clr has priority over a same-cycle set. Sticky flags are not cleared by run=0.
//  rst mid-operation: adc_req, cam_grant and sample_valid read 0 at the edge where rst is sampled; no partial sample is emitted.
//  adc_ack outside REQ is ignored.
// TESTING
//  T1 run=1, mask=4'b1111, ack 3 cycles after req, data=8'h10+ch:
//   -> 4 sample_valid pulses, ch 0,1,2,3, data 10,11,12,13.
//   -> Each req follows mux_sel change by 16 cycles.
//  T2 mask=4'b1010 -> only ch1 then ch3 sampled; mask=0 -> no adc_req for 3 periods.
//  T3 adc_ack never on ch2 -> adc_req high exactly 255 cycles, timeout_err=1, no ch2 sample, ch3 sampled next.
//   Then err_clr -> timeout_err=0.
//  T4 cam_req rises during ch1 SETTLE:
//   -> ch1 completes; cam_grant=1 before any ch2 mux change; no adc_req while granted.
//   -> cam_req low -> ch2, ch3 sampled.
//  T5 SCAN_PERIOD=32 with 10-cycle ack delay (scan > period):
//   -> overrun=1; the next scan starts the cycle after IDLE is entered; only one extra scan per backlog.
//  T6 rst pulse while in REQ -> next cycle all outputs 0; after release with run=1 the first scan starts on tick at count 1023.

Source files
------------

// File: rtl/sensor_scan_scheduler.sv
// Sensor scan scheduler: sequences four sensor channels through a shared
// ADC and arbitrates the pixel bus with camera frames at channel boundaries.
module sensor_scan_scheduler #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ACK_TIMEOUT   = 255,
    parameter int SCAN_PERIOD   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] ch_mask,
    output logic       adc_req,
    input  logic       adc_ack,
    input  logic [7:0] adc_data,
    output logic [1:0] mux_sel,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic [7:0] sample_data,
    input  logic       cam_req,
    output logic       cam_grant,
    output logic       busy,
    input  logic       err_clr,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int CMAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(SCAN_PERIOD);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] PER_LAST    = PW'(SCAN_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        CAP,
        NEXT,
        CAM
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ch_q, ch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] per_q, per_d;
    logic [7:0]    data_q, data_d;
    logic          pend_q, pend_d;
    logic          resume_q, resume_d;
    logic [1:0]    rch_q, rch_d;
    logic          terr_q, terr_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic          terr_set;
    logic [1:0]    first_ch;
    logic          first_ok;
    logic [1:0]    next_ch;
    logic          next_ok;

    assign tick = (per_q == PER_LAST);

    // Lowest enabled channel, used to start a fresh scan
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = 2'(i);
                first_ok = 1'b1;
            end
        end
    end

    // Lowest enabled channel strictly above the current one (no wrap)
    always_comb begin
        next_ch = '0;
        next_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_mask[i] && (i > int'(ch_q))) begin
                next_ch = 2'(i);
                next_ok = 1'b1;
            end
        end
    end

    // Period timer: free-runs while run=1, parked at zero otherwise
    always_comb begin
        per_d = per_q + PW'(1);
        if (!run || tick) begin
            per_d = '0;
        end
    end

    // Scan sequencer next-state logic
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        resume_d = resume_q;
        rch_d    = rch_q;
        terr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cam_req) begin
                    state_d  = CAM;
                    resume_d = 1'b0;
                end else if ((tick || pend_q) && first_ok) begin
                    state_d = SETTLE;
                    ch_d    = first_ch;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REQ: begin
                if (adc_ack) begin
                    data_d  = adc_data;
                    state_d = CAP;
                end else if (cnt_q == ACK_LAST) begin
                    terr_set = 1'b1;
                    state_d  = NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CAP: begin
                state_d = NEXT;
            end
            NEXT: begin
                if (cam_req) begin
                    state_d  = CAM;
                    resume_d = next_ok;
                    rch_d    = next_ch;
                end else if (next_ok && run) begin
                    state_d = SETTLE;
                    ch_d    = next_ch;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CAM: begin
                if (!cam_req) begin
                    if (resume_q && run) begin
                        state_d = SETTLE;
                        ch_d    = rch_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending start and sticky flags; err_clr wins over a same-cycle set
    always_comb begin
        pend_d = pend_q;
        if ((state_q == IDLE) && !cam_req) begin
            pend_d = 1'b0;
        end
        if (tick && ((state_q != IDLE) || cam_req)) begin
            pend_d = 1'b1;
        end
        terr_d = terr_q | terr_set;
        ovr_d  = ovr_q | (tick && (state_q != IDLE));
        if (err_clr) begin
            terr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            per_q    <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            resume_q <= 1'b0;
            rch_q    <= '0;
            terr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            resume_q <= resume_d;
            rch_q    <= rch_d;
            terr_q   <= terr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign adc_req      = (state_q == REQ);
    assign sample_valid = (state_q == CAP);
    assign cam_grant    = (state_q == CAM);
    assign busy         = (state_q != IDLE);
    assign mux_sel      = ch_q;
    assign sample_ch    = ch_q;
    assign sample_data  = data_q;
    assign timeout_err  = terr_q;
    assign overrun      = ovr_q;

endmodule
